// File: rtl/control_acceso_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_acceso_pkg : shared state encoding and default gate PIN      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package control_acceso_pkg;

   typedef enum logic [1:0] {
      ESPERA  = 2'b00,
      INGRESO = 2'b01,
      PASO    = 2'b10,
      BLOQUEO = 2'b11
   } estado_t;

   localparam logic [15:0] CLAVE_DEFECTO = 16'h2468;

endpackage : control_acceso_pkg
`default_nettype wire

// File: rtl/temporizador_apertura.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | temporizador_apertura : gate-open cycle counter, flags T_APERTURA-1  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module temporizador_apertura #(
   parameter int T_APERTURA = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expirado_o
);

   localparam int CW = (T_APERTURA > 1) ? $clog2(T_APERTURA) : 1;
   localparam logic [CW-1:0] C_ULTIMO = CW'(T_APERTURA - 1);

   logic [CW-1:0] cuenta_q;
   logic [CW-1:0] cuenta_d;

   always_comb begin
      cuenta_d = cuenta_q;
      if (clear_i) begin
         cuenta_d = '0;
      end else if (enable_i && (cuenta_q != C_ULTIMO)) begin
         cuenta_d = cuenta_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cuenta_q <= '0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign expirado_o = (cuenta_q == C_ULTIMO);

endmodule : temporizador_apertura
`default_nettype wire

// File: rtl/control_acceso_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_acceso_param : parking-gate access FSM with PIN retries,     |
// | lockout, open timeout and tailgate detection; registered outputs.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_acceso_param
   import control_acceso_pkg::*;
#(
   parameter int               PIN_W          = 16,
   parameter logic [PIN_W-1:0] CLAVE_CORRECTA = PIN_W'(CLAVE_DEFECTO),
   parameter int               MAX_INTENTOS   = 3,
   parameter int               T_APERTURA     = 100,
   localparam int              IW             = $clog2(MAX_INTENTOS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             llegado_vehiculo,
   input  logic             paso_vehiculo,
   input  logic             clave_valida,
   input  logic [PIN_W-1:0] clave_ingresada,
   input  logic             boton_reset,
   output logic             abriendo_compuerta,
   output logic             cerrando_compuerta,
   output logic             alarm_pin_incorrecto,
   output logic             alarm_bloqueo,
   output logic [IW-1:0]    intentos
);

   localparam logic [IW-1:0] C_MAX = IW'(MAX_INTENTOS);

   estado_t         estado_q, estado_d;
   logic            abriendo_q, abriendo_d;
   logic            cerrando_q, cerrando_d;
   logic            alarm_pin_q, alarm_pin_d;
   logic            alarm_bloq_q, alarm_bloq_d;
   logic [IW-1:0]   intentos_q, intentos_d;

   logic            w_expirado;
   logic            w_clave_ok;
   logic [IW-1:0]   w_intentos_inc;
   logic            w_agotado;

   temporizador_apertura #(
      .T_APERTURA (T_APERTURA)
   ) u_temporizador (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (estado_q != PASO),
      .enable_i   (estado_q == PASO),
      .expirado_o (w_expirado)
   );

   assign w_clave_ok     = (clave_ingresada == CLAVE_CORRECTA);
   assign w_intentos_inc = intentos_q + IW'(1);
   assign w_agotado      = (w_intentos_inc == C_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q     <= ESPERA;
         abriendo_q   <= 1'b0;
         cerrando_q   <= 1'b0;
         alarm_pin_q  <= 1'b0;
         alarm_bloq_q <= 1'b0;
         intentos_q   <= '0;
      end else begin
         estado_q     <= estado_d;
         abriendo_q   <= abriendo_d;
         cerrando_q   <= cerrando_d;
         alarm_pin_q  <= alarm_pin_d;
         alarm_bloq_q <= alarm_bloq_d;
         intentos_q   <= intentos_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         ESPERA: begin
            if (llegado_vehiculo) estado_d = INGRESO;
         end
         INGRESO: begin
            if (clave_valida) begin
               if (w_clave_ok)     estado_d = PASO;
               else if (w_agotado) estado_d = BLOQUEO;
            end
         end
         PASO: begin
            // Tailgate outranks a normal crossing, which outranks the timeout.
            if (paso_vehiculo && llegado_vehiculo) estado_d = BLOQUEO;
            else if (paso_vehiculo || w_expirado)  estado_d = ESPERA;
         end
         BLOQUEO: begin
            if (boton_reset) estado_d = ESPERA;
         end
         default: estado_d = ESPERA;
      endcase
   end

   always_comb begin
      abriendo_d   = 1'b0;
      cerrando_d   = 1'b0;
      alarm_pin_d  = alarm_pin_q;
      alarm_bloq_d = alarm_bloq_q;
      intentos_d   = intentos_q;
      case (estado_q)
         ESPERA: begin
            if (llegado_vehiculo) intentos_d = '0;
         end
         INGRESO: begin
            if (clave_valida) begin
               if (w_clave_ok) begin
                  abriendo_d  = 1'b1;
                  alarm_pin_d = 1'b0;
                  intentos_d  = '0;
               end else begin
                  alarm_pin_d = 1'b1;
                  intentos_d  = w_intentos_inc;
                  if (w_agotado) alarm_bloq_d = 1'b1;
               end
            end
         end
         PASO: begin
            if (paso_vehiculo && llegado_vehiculo) begin
               alarm_bloq_d = 1'b1;
            end else if (paso_vehiculo || w_expirado) begin
               cerrando_d = 1'b1;
            end else begin
               abriendo_d = 1'b1;
            end
         end
         BLOQUEO: begin
            alarm_bloq_d = 1'b1;
            if (boton_reset) begin
               alarm_bloq_d = 1'b0;
               alarm_pin_d  = 1'b0;
               intentos_d   = '0;
            end
         end
         default: ;
      endcase
   end

   assign abriendo_compuerta   = abriendo_q;
   assign cerrando_compuerta   = cerrando_q;
   assign alarm_pin_incorrecto = alarm_pin_q;
   assign alarm_bloqueo        = alarm_bloq_q;
   assign intentos             = intentos_q;

endmodule : control_acceso_param
`default_nettype wire

// File: tb/tb_control_acceso_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_acceso_param : scoreboard bench with reference model      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_control_acceso_param;

   localparam int          PIN_W = 16;
   localparam logic [15:0] KEY   = 16'h2468;
   localparam int          MAXI  = 3;
   localparam int          TAP   = 8;
   localparam int          IW    = $clog2(MAXI + 1);

   localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_LOCK = 3;

   typedef logic [IW+3:0] outv_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             llegado_vehiculo = 1'b0;
   logic             paso_vehiculo = 1'b0;
   logic             clave_valida = 1'b0;
   logic [PIN_W-1:0] clave_ingresada = '0;
   logic             boton_reset = 1'b0;
   logic             abriendo_compuerta;
   logic             cerrando_compuerta;
   logic             alarm_pin_incorrecto;
   logic             alarm_bloqueo;
   logic [IW-1:0]    intentos;

   always #5 clk = ~clk;

   control_acceso_param #(
      .PIN_W          (PIN_W),
      .CLAVE_CORRECTA (KEY),
      .MAX_INTENTOS   (MAXI),
      .T_APERTURA     (TAP)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .llegado_vehiculo     (llegado_vehiculo),
      .paso_vehiculo        (paso_vehiculo),
      .clave_valida         (clave_valida),
      .clave_ingresada      (clave_ingresada),
      .boton_reset          (boton_reset),
      .abriendo_compuerta   (abriendo_compuerta),
      .cerrando_compuerta   (cerrando_compuerta),
      .alarm_pin_incorrecto (alarm_pin_incorrecto),
      .alarm_bloqueo        (alarm_bloqueo),
      .intentos             (intentos)
   );

   outv_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    edge_n = 0;

   // Reference model: abstract mode plus the edge number at which the gate opened.
   int m_mode = M_IDLE;
   bit m_open, m_close, m_apin, m_abloq;
   int m_tries = 0;
   int opened_at = 0;

   task automatic model_edge(input bit rst, input bit lleg, input bit paso,
                             input bit cv, input logic [15:0] pin, input bit bot);
      if (!rst) begin
         m_mode = M_IDLE; m_open = 0; m_close = 0; m_apin = 0; m_abloq = 0; m_tries = 0;
         return;
      end
      m_close = 0;
      case (m_mode)
         M_IDLE: if (lleg) begin m_mode = M_ENTRY; m_tries = 0; end
         M_ENTRY: if (cv) begin
            if (pin == KEY) begin
               m_mode = M_OPEN; m_tries = 0; m_apin = 0; m_open = 1; opened_at = edge_n;
            end else begin
               m_tries = m_tries + 1; m_apin = 1;
               if (m_tries >= MAXI) begin m_mode = M_LOCK; m_abloq = 1; end
            end
         end
         M_OPEN: begin
            if (paso && lleg) begin
               m_mode = M_LOCK; m_open = 0; m_abloq = 1;
            end else if (paso || (edge_n - opened_at >= TAP)) begin
               m_mode = M_IDLE; m_open = 0; m_close = 1;
            end
         end
         default: if (bot) begin
            m_mode = M_IDLE; m_tries = 0; m_apin = 0; m_abloq = 0;
         end
      endcase
   endtask

   task automatic step(input bit rst, input bit lleg, input bit paso,
                       input bit cv, input logic [15:0] pin, input bit bot);
      @(negedge clk);
      reset = rst; llegado_vehiculo = lleg; paso_vehiculo = paso;
      clave_valida = cv; clave_ingresada = pin; boton_reset = bot;
      edge_n++;
      model_edge(rst, lleg, paso, cv, pin, bot);
      exp_q.push_back({m_open, m_close, m_apin, m_abloq, IW'(m_tries)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 16'h0000, 0);
   endtask

   // Monitor: every clock edge presents a fresh registered output word.
   initial begin
      outv_t e, g;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {abriendo_compuerta, cerrando_compuerta, alarm_pin_incorrecto,
                 alarm_bloqueo, intentos};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got open=%b close=%b apin=%b abloq=%b tries=%0d expected open=%b close=%b apin=%b abloq=%b tries=%0d",
                        $time, g[IW+3], g[IW+2], g[IW+1], g[IW], g[IW-1:0],
                        e[IW+3], e[IW+2], e[IW+1], e[IW], e[IW-1:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      // Happy path
      step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, KEY, 0);
      idle(2);
      step(1, 0, 1, 0, 0, 0);
      idle(2);
      // Lockout with gaps, then ignored correct PIN, then unlock
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 16'h1111, 0); idle(1);
      step(1, 0, 0, 1, 16'h1111, 0); idle(2);
      step(1, 0, 0, 1, 16'h1111, 0);
      step(1, 0, 0, 1, KEY, 0); step(1, 1, 1, 1, KEY, 0); idle(1);
      step(1, 0, 0, 0, 0, 1); idle(1);
      // Recovery after one wrong PIN
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 16'h1111, 0);
      step(1, 0, 0, 1, KEY, 0);
      step(1, 0, 1, 0, 0, 0); idle(1);
      // Timeout
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, KEY, 0);
      idle(TAP + 3);
      // Tailgate
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, KEY, 0); idle(1);
      step(1, 1, 1, 0, 0, 0); idle(2);
      step(1, 0, 0, 0, 0, 1); idle(1);
      // Reset mid-PASO, then strobe-less PIN
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 1, KEY, 0); idle(1);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, KEY, 0); step(1, 0, 0, 0, KEY, 0);
      step(1, 0, 0, 1, KEY, 0);
      step(1, 0, 1, 0, 0, 0); idle(1);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 200) != 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
              ($urandom % 3) == 0, (($urandom % 2) == 0) ? KEY : 16'($urandom),
              ($urandom % 8) == 0);
      end
      idle(2);
      repeat (3) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_control_acceso_param
`default_nettype wire

// File: doc/control_acceso_param.md
Name: control_acceso_param

Overview:
Parametrised parking-gate access controller and the next generation of the single-PIN gate FSM. It adds a configurable PIN width, key value and retry limit, plus a PIN-valid strobe handshake and registered attempt counting. It also adds a gate-open timeout, tailgate detection and fully registered outputs. It sits between the vehicle sensors/keypad and the gate actuator and alarm panel.

Parameters:
PIN_W, 16, width of the entered and stored PIN
CLAVE_CORRECTA, 16'h2468 (PIN_W bits), fixed correct PIN
MAX_INTENTOS, 3, wrong PINs that trigger lockout (>=1)
T_APERTURA, 100, max clk cycles the gate stays open waiting for a vehicle to pass (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge clears the block)
llegado_vehiculo  input  1  vehicle present at entry sensor
paso_vehiculo  input  1  vehicle crossing gate sensor
clave_valida  input  1  one-cycle strobe: clave_ingresada is a new PIN attempt
clave_ingresada  input  PIN_W  entered PIN, sampled only when clave_valida=1
boton_reset  input  1  operator unlock button
abriendo_compuerta  output  1  gate open command, level while open
cerrando_compuerta  output  1  one-cycle close pulse
alarm_pin_incorrecto  output  1  wrong-PIN alarm, level
alarm_bloqueo  output  1  lockout alarm, level
intentos  output  $clog2(MAX_INTENTOS+1)  current wrong-attempt count

Behaviour:
- One clock; reset synchronous active-low. Reset value of every output is 0; state ESPERA; internal attempt counter and timer 0. Reset wins over all inputs, including mid-PASO: the gate command drops the next cycle and no close pulse is generated.
- All outputs are registered and change on the clk edge that changes state (1-cycle latency from the causing input).
- States (shared package): ESPERA=2'b00, INGRESO=2'b01, PASO=2'b10, BLOQUEO=2'b11.
- ESPERA: llegado_vehiculo=1 -> INGRESO, intentos:=0. clave_valida, paso_vehiculo and boton_reset are ignored.
- INGRESO: only cycles with clave_valida=1 count as attempts; no strobe means stay.
  - Correct PIN -> PASO; intentos:=0; alarm_pin_incorrecto:=0; abriendo_compuerta:=1; timer:=0.
  - Wrong PIN -> intentos+1 and alarm_pin_incorrecto:=1, held until the block leaves INGRESO for PASO or ESPERA, or until reset.
  - If the incremented value equals MAX_INTENTOS -> BLOQUEO on the same edge; intentos saturates at MAX_INTENTOS and never wraps.
- PASO: abriendo_compuerta stays 1; timer increments every cycle. Exits are evaluated in this priority order:
  1. paso_vehiculo=1 and llegado_vehiculo=1 (tailgate) -> BLOQUEO; abriendo:=0; no close pulse.
  2. paso_vehiculo=1 alone -> ESPERA; abriendo:=0; cerrando_compuerta=1 for exactly one cycle.
  3. timer reaches T_APERTURA-1 with no paso -> ESPERA with the same close pulse (gate open for exactly T_APERTURA cycles).
- BLOQUEO: alarm_bloqueo=1, abriendo=0. alarm_pin_incorrecto stays 1 if entered via retries and stays 0 if entered via tailgate. boton_reset=1 -> ESPERA; clears intentos and both alarms. All other inputs are ignored.
- boton_reset has no effect outside BLOQUEO.
- intentos output mirrors the internal counter.

Decomposition:
- Package control_acceso_pkg: state typedef/encoding and default CLAVE_CORRECTA.
- Sub-module temporizador_apertura (parameter T_APERTURA): inputs clear and enable; output expirado, asserted when count==T_APERTURA-1. Instantiated once for the PASO timeout.
- Main module: state register, attempt counter, registered output logic.

Test Plan:
1. Happy path: reset low 2 cycles; llegado=1; strobe clave=16'h2468 -> next cycle abriendo=1, intentos=0. Then paso=1, llegado=0 -> abriendo=0, cerrando=1 for one cycle, state ESPERA.
2. Lockout: in INGRESO, strobe 16'h1111 three times (gaps allowed) -> intentos 1,2,3; alarm_pin_incorrecto=1 after the first. Third strobe -> alarm_bloqueo=1. Later strobes with 16'h2468 ignored. boton_reset=1 -> all outputs 0, ESPERA.
3. Recovery: wrong PIN once, then 16'h2468 -> alarm_pin_incorrecto drops with abriendo rising on the same edge; intentos=0.
4. Timeout: open gate with T_APERTURA=8 and no paso -> abriendo high exactly 8 cycles, then a single cerrando pulse, state ESPERA.
5. Tailgate: in PASO, paso=1 and llegado=1 in the same cycle -> alarm_bloqueo=1, abriendo=0, cerrando stays 0.
6. Reset mid-PASO and strobe without clave_valida: reset=0 while open -> all outputs 0 next edge. clave_ingresada=16'h2468 with clave_valida=0 in INGRESO -> no state change.
